// File: rtl/gs_fpga_cfg_loader.sv
// gs_fpga_cfg_loader: hardware initiator for the NeoGS CPLD FPGA-configuration
// port. It pulses nCONFIG, polls nSTATUS, streams a bitstream into port 11 and
// confirms CONF_DONE, issuing Z80-style IO cycles on the shared bus.
//
// Optional build macro: GS_CFG_LOADER_STATUS_CHECK_EN adds a nSTATUS read
// (CHK state) after every non-last bitstream byte.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start, bus released
// CFG_LO   | write 0x80 to port 10 (cold flag set, nCONFIG low)
// WAIT_LO  | hold nCONFIG low for NCFG_LOW_CYC clocks
// CFG_HI   | write 0x81 to port 10 (nCONFIG released)
// POLL_ST  | read port 10 until nSTATUS (d7) is high
// FETCH    | wait for a bitstream byte from the source
// WRITE    | write the byte to port 11
// CHK      | read port 10, nSTATUS must still be high (optional)
// POLL_DN  | read port 10 until CONF_DONE (d0) is high
// DONE     | one clock: success reported, back to IDLE
// ERR      | one clock: failure reported, back to IDLE

module gs_fpga_cfg_loader #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int NCFG_LOW_CYC = 64,
    parameter int POLL_LIMIT   = 1024,
    parameter int CNT_W        = 16,
    parameter int BYTES_W      = 24
) (
    input  logic               clkin,
    input  logic               coldres_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [BYTES_W-1:0] byte_cnt,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic               iorq_n,
    output logic               rd_n,
    output logic               wr_n,
    output logic               a7,
    output logic               a6,
    output logic [7:0]         d_out,
    output logic               d_oe,
    input  logic [7:0]         d_in
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_CFG_LO, ST_WAIT_LO, ST_CFG_HI, ST_POLL_ST, ST_FETCH,
        ST_WRITE, ST_POLL_DN, ST_DONE, ST_ERR
`ifdef GS_CFG_LOADER_STATUS_CHECK_EN
        , ST_CHK
`endif
    } state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_ADDR, PH_STROBE, PH_HOLD} phase_t;

    state_t           state, state_next;
    phase_t           phase;
    logic [CNT_W-1:0] bus_cnt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_r;
    logic             last_r;
    logic             st_bit;
    logic             cd_bit;
    logic             s_ready_r;
    logic             hs;
    logic             bus_end;
    logic             next_is_bus;
    logic             wr_cyc;
    logic             port11;
    logic [1:0]       err_next;
    logic             unused_din;

    assign hs         = s_valid && s_ready_r;
    assign bus_end    = (phase == PH_HOLD);
    assign s_ready    = s_ready_r;
    assign unused_din = ^d_in[6:1];

    // State register
    always_ff @(posedge clkin) begin
        if (!coldres_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    // Next-state logic; bus states advance only at the HOLD clock of their cycle
    always_comb begin
        state_next = state;
        err_next   = 2'd0;
        case (state)
            ST_IDLE:    if (start) state_next = ST_CFG_LO;
            ST_CFG_LO:  if (bus_end) state_next = ST_WAIT_LO;
            ST_WAIT_LO: if (cnt == '0) state_next = ST_CFG_HI;
            ST_CFG_HI:  if (bus_end) state_next = ST_POLL_ST;
            ST_POLL_ST: if (bus_end) begin
                if (st_bit)           state_next = ST_FETCH;
                else if (cnt == '0) begin
                    state_next = ST_ERR;
                    err_next   = 2'd1;
                end
            end
            ST_FETCH:   if (hs) state_next = ST_WRITE;
            ST_WRITE:   if (bus_end) begin
                if (last_r) state_next = ST_POLL_DN;
`ifdef GS_CFG_LOADER_STATUS_CHECK_EN
                else        state_next = ST_CHK;
`else
                else        state_next = ST_FETCH;
`endif
            end
`ifdef GS_CFG_LOADER_STATUS_CHECK_EN
            ST_CHK:     if (bus_end) begin
                if (st_bit) state_next = ST_FETCH;
                else begin
                    state_next = ST_ERR;
                    err_next   = 2'd2;
                end
            end
`endif
            ST_POLL_DN: if (bus_end) begin
                if (cd_bit)           state_next = ST_DONE;
                else if (cnt == '0) begin
                    state_next = ST_ERR;
                    err_next   = 2'd3;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            ST_ERR:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase

        case (state_next)
            ST_CFG_LO, ST_CFG_HI, ST_POLL_ST, ST_WRITE, ST_POLL_DN: next_is_bus = 1'b1;
`ifdef GS_CFG_LOADER_STATUS_CHECK_EN
            ST_CHK:  next_is_bus = 1'b1;
`endif
            default: next_is_bus = 1'b0;
        endcase
    end

    // Bus cycle engine: a new cycle starts on the same edge a bus state is entered
    // (or re-entered for repeated polls), so consecutive reads run back to back
    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            phase   <= PH_IDLE;
            bus_cnt <= '0;
            st_bit  <= 1'b0;
            cd_bit  <= 1'b0;
        end else begin
            case (phase)
                PH_ADDR: begin
                    if (bus_cnt == '0) begin
                        phase   <= PH_STROBE;
                        bus_cnt <= CNT_W'(STROBE_CYC - 1);
                    end else begin
                        bus_cnt <= bus_cnt - CNT_W'(1);
                    end
                end
                PH_STROBE: begin
                    if (bus_cnt == '0) begin
                        phase  <= PH_HOLD;
                        st_bit <= d_in[7];
                        cd_bit <= d_in[0];
                    end else begin
                        bus_cnt <= bus_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (next_is_bus) begin
                        phase   <= PH_ADDR;
                        bus_cnt <= CNT_W'(SETUP_CYC - 1);
                    end else begin
                        phase <= PH_IDLE;
                    end
                end
            endcase
        end
    end

    // Sequencer datapath: shared wait/poll down-counter, byte capture, status flags
    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            cnt       <= '0;
            data_r    <= 8'h00;
            last_r    <= 1'b0;
            s_ready_r <= 1'b0;
            byte_cnt  <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            if (state_next != state && state_next == ST_WAIT_LO)
                cnt <= CNT_W'(NCFG_LOW_CYC - 1);
            else if (state_next != state &&
                     (state_next == ST_POLL_ST || state_next == ST_POLL_DN))
                cnt <= CNT_W'(POLL_LIMIT - 1);
            else if (state == ST_WAIT_LO ||
                     ((state == ST_POLL_ST || state == ST_POLL_DN) && bus_end))
                cnt <= cnt - CNT_W'(1);

            s_ready_r <= (state == ST_FETCH) && !hs;
            if (state == ST_FETCH && hs) begin
                data_r <= s_data;
                last_r <= s_last;
            end

            if (state == ST_IDLE && start) begin
                byte_cnt <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= 2'd0;
            end else begin
                if (state == ST_WRITE && bus_end && byte_cnt != '1)
                    byte_cnt <= byte_cnt + BYTES_W'(1);
                if (state_next == ST_DONE)
                    done <= 1'b1;
                if (state_next == ST_ERR) begin
                    error    <= 1'b1;
                    err_code <= err_next;
                end
            end
        end
    end

    // Output decode: bus pins from the cycle phase, payload from the FSM state
    always_comb begin
        wr_cyc = 1'b0;
        port11 = 1'b0;
        d_out  = 8'h00;
        case (state)
            ST_CFG_LO: begin wr_cyc = 1'b1; d_out = 8'h80; end
            ST_CFG_HI: begin wr_cyc = 1'b1; d_out = 8'h81; end
            ST_WRITE:  begin wr_cyc = 1'b1; port11 = 1'b1; d_out = data_r; end
            default:   ;
        endcase
        iorq_n = (phase != PH_STROBE);
        rd_n   = !((phase == PH_STROBE) && !wr_cyc);
        wr_n   = !((phase == PH_STROBE) && wr_cyc);
        a7     = (phase != PH_IDLE);
        a6     = (phase != PH_IDLE) && port11;
        d_oe   = (phase != PH_IDLE) && wr_cyc;
        busy   = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
    end

endmodule
